// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
//   Shared defaults and types for the multi-port register file.
//   - DEF_DATA_W / DEF_ADDR_W : default register width and index width
//   - reg_idx_t / reg_data_t  : index and data types at the default sizes
//   - wr_port_t               : one write-port bundle (enable, index, data)
// -----------------------------------------------------------------------------
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  typedef logic [DEF_ADDR_W-1:0] reg_idx_t;
  typedef logic [DEF_DATA_W-1:0] reg_data_t;

  typedef struct packed {
    logic      en;
    reg_idx_t  idx;
    reg_data_t data;
  } wr_port_t;

endpackage : regfile_pkg

// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
//   One pending bit per register, tracking an issued-but-not-yet-written
//   destination. Produces RAW-hazard busy flags for the two read ports.
// Ports
//   clk, rst          clock; asynchronous active-low reset
//   wr0_valid, Rw0    qualified write on port 0 (already masked for reg 0)
//   wr1_valid, Rw1    qualified write on port 1
//   iss_en, iss_rd    instruction issue with destination register
//   Ra, Rb            read indices
//   busyA, busyB      read index has an outstanding producer this cycle
//   stall             busyA | busyB
// -----------------------------------------------------------------------------
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr0_valid,
  input  logic [ADDR_W-1:0] Rw0,
  input  logic              wr1_valid,
  input  logic [ADDR_W-1:0] Rw1,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_rd,
  input  logic [ADDR_W-1:0] Ra,
  input  logic [ADDR_W-1:0] Rb,
  output logic              busyA,
  output logic              busyB,
  output logic              stall
);

  localparam int NREG = 2 ** ADDR_W;

  logic [NREG-1:0] pending;
  logic [NREG-1:0] set_vec;
  logic [NREG-1:0] clr_vec;
  logic            iss_valid;
  logic            hit_a;
  logic            hit_b;

  // Issuing to the hardwired zero register creates no producer to wait for.
  assign iss_valid = iss_en && !((ZERO_REG != 0) && (iss_rd == '0));

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (iss_valid) set_vec = NREG'(1) << iss_rd;
    if (wr0_valid) clr_vec = clr_vec | (NREG'(1) << Rw0);
    if (wr1_valid) clr_vec = clr_vec | (NREG'(1) << Rw1);
  end

  // Set is applied after clear: an issue in the same cycle as a retiring
  // write to that register names a newer producer that is still outstanding.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pending <= '0;
    else      pending <= (pending & ~clr_vec) | set_vec;
  end

  // With bypass, a write landing this cycle already satisfies the read.
  always_comb begin
    hit_a = 1'b0;
    hit_b = 1'b0;
    if (BYPASS != 0) begin
      hit_a = (wr0_valid && (Rw0 == Ra)) || (wr1_valid && (Rw1 == Ra));
      hit_b = (wr0_valid && (Rw0 == Rb)) || (wr1_valid && (Rw1 == Rb));
    end
  end

  assign busyA = pending[Ra] && !hit_a && !((ZERO_REG != 0) && (Ra == '0));
  assign busyB = pending[Rb] && !hit_b && !((ZERO_REG != 0) && (Rb == '0));
  assign stall = busyA | busyB;

endmodule : regfile_scoreboard

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
//   2-write / 2-read register file with optional write-through bypass,
//   optional hardwired zero register and a pending-write scoreboard for
//   RAW-hazard stalls in decode.
// Ports
//   clk, rst              clock; asynchronous active-low reset
//   wEn0, Rw0, busW0      write port 0
//   wEn1, Rw1, busW1      write port 1 (wins on index collision)
//   Ra, Rb / busA, busB   read indices / combinational read data
//   iss_en, iss_rd        issue of an instruction writing iss_rd
//   busyA, busyB, stall   outstanding-write flags for Ra, Rb and their OR
// -----------------------------------------------------------------------------
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wEn0,
  input  logic [ADDR_W-1:0] Rw0,
  input  logic [DATA_W-1:0] busW0,
  input  logic              wEn1,
  input  logic [ADDR_W-1:0] Rw1,
  input  logic [DATA_W-1:0] busW1,
  input  logic [ADDR_W-1:0] Ra,
  input  logic [ADDR_W-1:0] Rb,
  output logic [DATA_W-1:0] busA,
  output logic [DATA_W-1:0] busB,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_rd,
  output logic              busyA,
  output logic              busyB,
  output logic              stall
);

  localparam int NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NREG];
  logic              wr0_valid;
  logic              wr1_valid;

  // Writes to the hardwired zero register are dropped at the source so both
  // the data array and the scoreboard see the same qualified write.
  assign wr0_valid = wEn0 && !((ZERO_REG != 0) && (Rw0 == '0));
  assign wr1_valid = wEn1 && !((ZERO_REG != 0) && (Rw1 == '0));

  // NOTE: the array is cleared on reset, so it maps to flops rather than a
  // RAM macro; that is required because every register must read 0 after reset.
  // Port 1 is assigned last, so on an index collision its value is stored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREG; r++) regs[r] <= '0;
    end else begin
      if (wr0_valid) regs[Rw0] <= busW0;
      if (wr1_valid) regs[Rw1] <= busW1;
    end
  end

  // Read mux priority: zero register, port 1 bypass, port 0 bypass, array.
  always_comb begin
    busA = regs[Ra];
    if ((BYPASS != 0) && wr0_valid && (Rw0 == Ra)) busA = busW0;
    if ((BYPASS != 0) && wr1_valid && (Rw1 == Ra)) busA = busW1;
    if ((ZERO_REG != 0) && (Ra == '0))              busA = '0;
  end

  always_comb begin
    busB = regs[Rb];
    if ((BYPASS != 0) && wr0_valid && (Rw0 == Rb)) busB = busW0;
    if ((BYPASS != 0) && wr1_valid && (Rw1 == Rb)) busB = busW1;
    if ((ZERO_REG != 0) && (Rb == '0))              busB = '0;
  end

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .wr0_valid (wr0_valid),
    .Rw0       (Rw0),
    .wr1_valid (wr1_valid),
    .Rw1       (Rw1),
    .iss_en    (iss_en),
    .iss_rd    (iss_rd),
    .Ra        (Ra),
    .Rb        (Rb),
    .busyA     (busyA),
    .busyB     (busyB),
    .stall     (stall)
  );

endmodule : regfile_mp

// File: tb/tb_regfile_mp.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp
//   Directed bench for regfile_mp. Two instances share all inputs: one with
//   write-through bypass and one without, so both read behaviours are checked
//   against hand-computed values.
// -----------------------------------------------------------------------------
module tb_regfile_mp;

  logic        clk;
  logic        rst;
  logic        wEn0, wEn1, iss_en;
  logic [4:0]  Rw0, Rw1, Ra, Rb, iss_rd;
  logic [31:0] busW0, busW1;

  logic [31:0] busA, busB, nb_busA, nb_busB;
  logic        busyA, busyB, stall, nb_busyA, nb_busyB, nb_stall;

  int n_cmp = 0;
  int n_err = 0;

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk(clk), .rst(rst),
    .wEn0(wEn0), .Rw0(Rw0), .busW0(busW0),
    .wEn1(wEn1), .Rw1(Rw1), .busW1(busW1),
    .Ra(Ra), .Rb(Rb), .busA(busA), .busB(busB),
    .iss_en(iss_en), .iss_rd(iss_rd),
    .busyA(busyA), .busyB(busyB), .stall(stall)
  );

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst),
    .wEn0(wEn0), .Rw0(Rw0), .busW0(busW0),
    .wEn1(wEn1), .Rw1(Rw1), .busW1(busW1),
    .Ra(Ra), .Rb(Rb), .busA(nb_busA), .busB(nb_busB),
    .iss_en(iss_en), .iss_rd(iss_rd),
    .busyA(nb_busyA), .busyB(nb_busyB), .stall(nb_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance past the next rising edge; inputs are then changed well away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wEn0 = 1'b0; wEn1 = 1'b0; iss_en = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    wEn0 = 1'b0; Rw0 = '0; busW0 = '0;
    wEn1 = 1'b0; Rw1 = '0; busW1 = '0;
    iss_en = 1'b0; iss_rd = '0;
    Ra = 5'd1; Rb = 5'd2;

    // Reset state
    #2;
    check("rst_busA", busA, 32'h0);
    check("rst_stall", {31'b0, stall}, 32'h0);
    tick();
    rst = 1'b1;

    // 1. All registers read zero after reset
    for (int i = 0; i < 32; i++) begin
      Ra = 5'(i);
      Rb = 5'(31 - i);
      #1;
      check($sformatf("rd_all_A%0d", i), busA, 32'h0);
      check($sformatf("rd_all_B%0d", i), busB, 32'h0);
      check($sformatf("rd_all_stall%0d", i), {31'b0, stall}, 32'h0);
    end

    wEn0 = 1'b1; Rw0 = 5'd5; busW0 = 32'hDEADBEEF;
    tick();
    idle();
    Ra = 5'd5;
    #1;
    check("wr_r5_busA", busA, 32'hDEADBEEF);
    check("wr_r5_nb_busA", nb_busA, 32'hDEADBEEF);

    // 2. Hardwired zero register
    wEn0 = 1'b1; Rw0 = 5'd0; busW0 = 32'h1234;
    Ra = 5'd0;
    #1;
    check("zero_bypass_busA", busA, 32'h0);
    tick();
    idle();
    #1;
    check("zero_stored_busA", busA, 32'h0);
    iss_en = 1'b1; iss_rd = 5'd0;
    tick();
    idle();
    #1;
    check("zero_iss_busyA", {31'b0, busyA}, 32'h0);
    check("zero_iss_nb_busyA", {31'b0, nb_busyA}, 32'h0);

    // 3. Dual write collision on r7: port 1 wins
    wEn0 = 1'b1; Rw0 = 5'd7; busW0 = 32'h1;
    wEn1 = 1'b1; Rw1 = 5'd7; busW1 = 32'h2;
    Ra = 5'd7; Rb = 5'd7;
    #1;
    check("coll_bypass_busA", busA, 32'h2);
    check("coll_bypass_busB", busB, 32'h2);
    check("coll_nb_busA", nb_busA, 32'h0);
    tick();
    idle();
    #1;
    check("coll_stored_busA", busA, 32'h2);
    check("coll_nb_stored_busA", nb_busA, 32'h2);

    // 4. Scoreboard hazard on r3
    iss_en = 1'b1; iss_rd = 5'd3;
    tick();
    idle();
    Ra = 5'd3; Rb = 5'd3;
    #1;
    check("sb_busyA", {31'b0, busyA}, 32'h1);
    check("sb_busyB", {31'b0, busyB}, 32'h1);
    check("sb_stall", {31'b0, stall}, 32'h1);
    check("sb_nb_busyA", {31'b0, nb_busyA}, 32'h1);
    Rb = 5'd5;
    wEn0 = 1'b1; Rw0 = 5'd3; busW0 = 32'hAA;
    #1;
    check("sb_wb_busyA", {31'b0, busyA}, 32'h0);
    check("sb_wb_busA", busA, 32'hAA);
    check("sb_wb_stall", {31'b0, stall}, 32'h0);
    check("sb_wb_nb_busyA", {31'b0, nb_busyA}, 32'h1);
    check("sb_wb_nb_busA", nb_busA, 32'h0);
    tick();
    idle();
    #1;
    check("sb_after_busyA", {31'b0, busyA}, 32'h0);
    check("sb_after_nb_busyA", {31'b0, nb_busyA}, 32'h0);
    check("sb_after_nb_busA", nb_busA, 32'hAA);
    check("sb_after_nb_stall", {31'b0, nb_stall}, 32'h0);

    // 5. Issue and write to r9 in the same cycle: set wins
    iss_en = 1'b1; iss_rd = 5'd9;
    wEn1 = 1'b1; Rw1 = 5'd9; busW1 = 32'h99;
    Ra = 5'd9;
    #1;
    check("set_clr_pre_busyA", {31'b0, busyA}, 32'h0);
    tick();
    idle();
    #1;
    check("set_clr_busyA", {31'b0, busyA}, 32'h1);
    check("set_clr_busA", busA, 32'h99);
    check("set_clr_nb_busyA", {31'b0, nb_busyA}, 32'h1);

    // Re-issue to already pending r9, then one write clears it
    iss_en = 1'b1; iss_rd = 5'd9;
    tick();
    idle();
    #1;
    check("reiss_busyA", {31'b0, busyA}, 32'h1);
    wEn0 = 1'b1; Rw0 = 5'd9; busW0 = 32'h100;
    tick();
    idle();
    #1;
    check("reiss_clr_busyA", {31'b0, busyA}, 32'h0);
    check("reiss_clr_busA", busA, 32'h100);

    // 6. Asynchronous reset with r4 = 0x55 and r4 pending
    wEn0 = 1'b1; Rw0 = 5'd4; busW0 = 32'h55;
    tick();
    idle();
    iss_en = 1'b1; iss_rd = 5'd4;
    tick();
    idle();
    Ra = 5'd4; Rb = 5'd4;
    #1;
    check("arst_pre_busA", busA, 32'h55);
    check("arst_pre_busyA", {31'b0, busyA}, 32'h1);
    rst = 1'b0;
    #1;
    check("arst_busA", busA, 32'h0);
    check("arst_busyA", {31'b0, busyA}, 32'h0);
    check("arst_stall", {31'b0, stall}, 32'h0);
    check("arst_nb_busB", nb_busB, 32'h0);
    Ra = 5'd5;
    #1;
    check("arst_r5_busA", busA, 32'h0);
    tick();
    rst = 1'b1;
    #1;
    check("post_rst_busA", busA, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_regfile_mp
